// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular buffer of free register numbers
// feeding rename (multi-lane pop) and fed by commit/recovery (multi-lane push).
// Optional macro RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN adds double-free tracking
// and the doubleFreeError output.
module phys_reg_free_list #(
    parameter int NUM_ENTRIES    = 32,
    parameter int FIRST_FREE_REG = 32,
    parameter int POP_WIDTH      = 2,
    parameter int PUSH_WIDTH     = 2,
    parameter int REG_WIDTH      = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [POP_WIDTH-1:0]              popReq,
    output logic                              popGrant,
    output logic [POP_WIDTH*REG_WIDTH-1:0]    popReg,
    input  logic [PUSH_WIDTH-1:0]             pushValid,
    input  logic [PUSH_WIDTH*REG_WIDTH-1:0]   pushReg,
    output logic [$clog2(NUM_ENTRIES):0]      freeCount,
    output logic                              canAllocateAll,
    output logic                              overflowError
`ifdef RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN
    ,
    output logic                              doubleFreeError
`endif
);

    localparam int PTR_W       = $clog2(NUM_ENTRIES);
    localparam int CNT_W       = PTR_W + 1;
    localparam int SUM_W       = CNT_W + 1;
    localparam int PSCALAR_NUM = FIRST_FREE_REG + NUM_ENTRIES;

    logic [REG_WIDTH-1:0] entries [NUM_ENTRIES];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    logic [CNT_W-1:0]     popN;
    logic [CNT_W-1:0]     grantN;
    logic [CNT_W-1:0]     pushN;
    logic [PTR_W-1:0]     popIdx;
    logic [PTR_W-1:0]     pushIdx [PUSH_WIDTH];
    logic [SUM_W-1:0]     nextSum;
    logic                 pushOk;

    // Pop side: compact requested lanes onto consecutive entries from head.
    always_comb begin
        popN   = '0;
        popReg = '0;
        popIdx = '0;
        for (int unsigned i = 0; i < POP_WIDTH; i++) begin
            if (popReq[i]) begin
                popIdx = head + popN[PTR_W-1:0];
                popReg[i*REG_WIDTH +: REG_WIDTH] = entries[popIdx];
                popN = popN + CNT_W'(1);
            end
        end
        popGrant       = (freeCount >= popN);
        canAllocateAll = (freeCount >= CNT_W'(POP_WIDTH));
    end

    // Push side: slot assignment and capacity check against post-pop occupancy.
    always_comb begin
        pushN = '0;
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
            pushIdx[i] = tail + pushN[PTR_W-1:0];
            if (pushValid[i]) begin
                pushN = pushN + CNT_W'(1);
            end
        end
        grantN  = popGrant ? popN : '0;
        nextSum = {1'b0, freeCount} - {1'b0, grantN} + {1'b0, pushN};
        pushOk  = (nextSum <= SUM_W'(NUM_ENTRIES));
    end

    // Buffer, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= REG_WIDTH'(FIRST_FREE_REG + i);
            end
            head          <= '0;
            tail          <= '0;
            freeCount     <= CNT_W'(NUM_ENTRIES);
            overflowError <= 1'b0;
        end else begin
            if (popGrant) begin
                head <= head + popN[PTR_W-1:0];
            end
            if (pushOk) begin
                for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
                    if (pushValid[i]) begin
                        entries[pushIdx[i]] <= pushReg[i*REG_WIDTH +: REG_WIDTH];
                    end
                end
                tail      <= tail + pushN[PTR_W-1:0];
                freeCount <= nextSum[CNT_W-1:0];
            end else begin
                // All pushes dropped this cycle; the pop still retires.
                freeCount     <= freeCount - grantN;
                overflowError <= 1'b1;
            end
        end
    end

`ifdef RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [PSCALAR_NUM-1:0] inFree;
    logic [PSCALAR_NUM-1:0] inFreeNext;
    logic                   dfHit;

    // Detect a release of a register already free, or duplicated across lanes.
    always_comb begin
        dfHit      = 1'b0;
        inFreeNext = inFree;
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
            if (pushValid[i]) begin
                if (inFree[pushReg[i*REG_WIDTH +: REG_WIDTH]]) begin
                    dfHit = 1'b1;
                end
                for (int unsigned j = 0; j < i; j++) begin
                    if (pushValid[j] &&
                        pushReg[j*REG_WIDTH +: REG_WIDTH] == pushReg[i*REG_WIDTH +: REG_WIDTH]) begin
                        dfHit = 1'b1;
                    end
                end
            end
        end
        if (popGrant) begin
            for (int unsigned i = 0; i < POP_WIDTH; i++) begin
                if (popReq[i]) begin
                    inFreeNext[popReg[i*REG_WIDTH +: REG_WIDTH]] = 1'b0;
                end
            end
        end
        if (pushOk) begin
            for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
                if (pushValid[i]) begin
                    inFreeNext[pushReg[i*REG_WIDTH +: REG_WIDTH]] = 1'b1;
                end
            end
        end
    end

    // Membership vector and sticky double-free flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PSCALAR_NUM; i++) begin
                inFree[i] <= (i >= FIRST_FREE_REG);
            end
            doubleFreeError <= 1'b0;
        end else begin
            inFree <= inFreeNext;
            if (dfHit) begin
                doubleFreeError <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Free list of scalar physical register numbers, feeding the rename stage.
- Allocates up to RENAME_WIDTH destination registers per cycle to renamed ops.
- Accepts up to COMMIT_WIDTH released registers per cycle from commit/recovery.
- Circular buffer of PRegNumPath-sized entries with a head pointer, a tail pointer and an occupancy counter; multi-lane pop/push every cycle.

Parameters:
- NUM_ENTRIES, 32 (PSCALAR_NUM - LSCALAR_NUM): capacity; power of two.
- FIRST_FREE_REG, 32 (LSCALAR_NUM): register number held in entry 0 at reset.
- POP_WIDTH, 2 (RENAME_WIDTH): allocate lanes.
- PUSH_WIDTH, 2 (COMMIT_WIDTH): release lanes.
- REG_WIDTH, 6 (PSCALAR_NUM_BIT_WIDTH): register number width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- popReq  in  POP_WIDTH  per-lane allocate request; may be sparse
- popGrant  out  1  all requested lanes served this cycle
- popReg  out  POP_WIDTH*REG_WIDTH  allocated register per lane; valid when popReq[i] and popGrant
- pushValid  in  PUSH_WIDTH  per-lane release valid; may be sparse
- pushReg  in  PUSH_WIDTH*REG_WIDTH  released register per lane
- freeCount  out  $clog2(NUM_ENTRIES)+1  current occupancy
- canAllocateAll  out  1  freeCount >= POP_WIDTH
- overflowError  out  1  sticky: push attempted beyond capacity

Behaviour:
- Reset:
  - entry[i] = FIRST_FREE_REG + i; head = 0; tail = 0; freeCount = NUM_ENTRIES (full).
  - overflowError = 0.
  - Combinational outputs evaluate from these values in the cycle after rst deasserts.
- Pop (combinational read, registered pointer update):
  - n = popcount(popReq).
  - popGrant = (freeCount >= n); with n = 0, popGrant = 1.
  - Lane i with popReq[i] set, being the k-th set lane (k from 0, lowest lane first), sees popReg[i] = entry[(head + k) mod NUM_ENTRIES].
  - popReg of unrequested lanes is don't-care; drive 0.
  - On grant, head += n at the clock edge. On refusal, nothing changes (all-or-nothing, no partial allocation).
- Push:
  - The k-th set pushValid lane writes entry[(tail + k) mod NUM_ENTRIES] at the clock edge.
  - tail += m, where m = popcount(pushValid).
- Simultaneous push and pop in one cycle:
  - popGrant uses freeCount before this cycle's pushes; no push-to-pop bypass, so a register released in cycle t can be allocated no earlier than t+1.
  - freeCount_next = freeCount - (granted n) + m.
- Full/overflow:
  - If freeCount - granted n + m > NUM_ENTRIES, drop all pushes that cycle and leave tail unchanged.
  - Pop still proceeds; freeCount_next = freeCount - granted n.
  - overflowError is set and holds until rst.
- Empty: freeCount = 0 with any popReq gives popGrant = 0.
- Wrap-around: pointers are $clog2(NUM_ENTRIES) bits and wrap naturally; lanes straddling index NUM_ENTRIES-1 to 0 must return the correct entries.
- Reset mid-operation: rst takes priority over same-cycle push/pop; full reset state next cycle.

Optional Feature:
- Macro: RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN.
- Defined:
  - Keep a PSCALAR_NUM-bit inFree vector. At reset, bits FIRST_FREE_REG..FIRST_FREE_REG+NUM_ENTRIES-1 are set, all others clear.
  - A granted pop clears the bits of the popped registers; an accepted push sets them.
  - Extra output doubleFreeError (sticky, reset 0) is set when a pushed register already has its bit set, or when two push lanes in one cycle carry the same register. The offending push is still written.
- Not defined: no vector, no port; doubleFreeError does not exist.

Test Plan:
- Reset then popReq=2'b11 -> popGrant=1, popReg={33,32} (lane1=33, lane0=32); next cycle freeCount=30.
- Sparse request popReq=2'b10 after reset -> lane1 gets 32; freeCount=31.
- 16 cycles of popReq=2'b11 from reset, then popReq=2'b01 -> popGrant=0, freeCount stays 0. In the same cycle push reg 40 -> freeCount=1 next cycle; popReq=2'b01 then grants 40.
- Wrap: pop 31, push 31 (regs 1..31), then pop 2 and push 2 so both pointers straddle 31->0 -> returned entries match push order, freeCount correct.
- Full state (after reset) with pushValid=2'b01 and no pop -> push dropped, overflowError=1 and stays 1 until rst.
- With RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN: after reset push reg 45 with one pop granted (count 31) -> doubleFreeError=1; push the same reg on both lanes -> doubleFreeError=1.
